vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 16 +
 rtl/vram_wr_fifo.sv | 70 +++++++
 rtl/vram_arbiter.sv | 126 ++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and default sizing for the character-RAM arbiter.
// The FSM state enum lives here so the top and any helper can share one encoding.
package vram_arb_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous CPU write buffer: push/pop in one cycle keeps count and order.
// Push while full and pop while empty are ignored.
module vram_wr_fifo
    import vram_arb_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port character RAM arbiter: VGA fetches have priority over buffered
// CPU writes, except that a write starved for STARVE_MAX cycles is forced in.
//
// state    | meaning
// ST_IDLE  | no access this cycle, ram_addr held, ram_we low
// ST_READ  | VGA fetch presented on ram_addr, vga_ack high
// ST_WRITE | FIFO head presented on ram_addr/ram_wdata, ram_we high
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int EW = ADDR_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              rd_pend_q;
    logic              vga_valid_q;
    logic [DATA_W-1:0] vga_rdata_q;
    logic              forced;

    logic [EW-1:0]     fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    assign cpu_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign fifo_push = cpu_we && !fifo_full;
    assign fifo_pop  = (state_d == ST_WRITE);

    vram_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock_50),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  ({cpu_addr, cpu_wdata}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = ST_IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        starve_d    = starve_q;
        forced      = !fifo_empty && (starve_q == SW'(STARVE_MAX));

        if (forced || (!vga_req && !fifo_empty)) begin
            state_d     = ST_WRITE;
            ram_addr_d  = fifo_head[EW-1:DATA_W];
            ram_wdata_d = fifo_head[DATA_W-1:0];
        end else if (vga_req) begin
            state_d    = ST_READ;
            ram_addr_d = vga_addr;
        end

        if (fifo_empty || state_d == ST_WRITE) begin
            starve_d = '0;
        end else if (state_d == ST_READ && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // RAM returns data one cycle after the address, so vga_rdata lands two
    // edges after the READ grant.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            starve_q    <= '0;
            rd_pend_q   <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            starve_q    <= starve_d;
            rd_pend_q   <= (state_q == ST_READ);
            vga_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                vga_rdata_q <= ram_rdata;
            end
        end
    end

    assign ram_we    = (state_q == ST_WRITE);
    assign vga_ack   = (state_q == ST_READ);
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign vga_valid = vga_valid_q;
    assign vga_rdata = vga_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand-built corner sequences,
// and random traffic checked against a queue-based model of the arbitration rules.
module tb_vram_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;
    localparam int NRAM  = 1 << AW;

    logic          clock_50 = 1'b0;
    logic          reset;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_ack;
    logic          vga_valid;
    logic [DW-1:0] vga_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic          ram_load;

    always #5 clock_50 = ~clock_50;

    vram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clock_50  (clock_50),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_ack   (vga_ack),
        .vga_valid (vga_valid),
        .vga_rdata (vga_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 'h010) return 8'h7E;
        return DW'(a * 37 + 11);
    endfunction

    // Synchronous single-port RAM, read-before-write.
    logic [DW-1:0] ram_mem [NRAM];
    always @(posedge clock_50) begin
        if (ram_load) begin
            for (int i = 0; i < NRAM; i++) ram_mem[i] <= init_val(i);
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0]    shadow [NRAM];
    logic [AW+DW-1:0] mq [$];
    int               vdue [$];
    logic [DW-1:0]    vdat [$];
    int               starve;
    int               cyc;
    logic             exp_we, exp_ack, exp_val, exp_rdy;
    logic [AW-1:0]    exp_addr;
    logic [DW-1:0]    exp_wd, exp_rd;

    task automatic model_reset();
        mq.delete();
        vdue.delete();
        vdat.delete();
        starve   = 0;
        exp_we   = 1'b0;
        exp_ack  = 1'b0;
        exp_val  = 1'b0;
        exp_rdy  = 1'b1;
        exp_addr = '0;
        exp_wd   = '0;
        exp_rd   = '0;
    endtask

    task automatic model_edge();
        logic             had_room, nonempty, forced;
        logic [AW+DW-1:0] w;
        cyc++;
        if (exp_we) shadow[exp_addr] = exp_wd;
        had_room = (mq.size() < DEPTH);
        nonempty = (mq.size() > 0);
        forced   = nonempty && (starve == SMAX);
        exp_we   = 1'b0;
        exp_ack  = 1'b0;
        if (forced || (!vga_req && nonempty)) begin
            w        = mq.pop_front();
            exp_we   = 1'b1;
            exp_addr = w[AW+DW-1:DW];
            exp_wd   = w[DW-1:0];
        end else if (vga_req) begin
            exp_ack  = 1'b1;
            exp_addr = vga_addr;
            vdue.push_back(cyc + 2);
            vdat.push_back(shadow[vga_addr]);
        end
        if (!nonempty || exp_we) starve = 0;
        else if (exp_ack && starve < SMAX) starve++;
        if (cpu_we && had_room) mq.push_back({cpu_addr, cpu_wdata});
        exp_val = 1'b0;
        if (vdue.size() > 0 && vdue[0] == cyc) begin
            exp_val = 1'b1;
            exp_rd  = vdat.pop_front();
            void'(vdue.pop_front());
        end
        exp_rdy = (mq.size() < DEPTH);
    endtask

    function automatic logic [29:0] obs();
        return {ram_we, vga_ack, vga_valid, cpu_ready, ram_addr, ram_wdata, vga_rdata};
    endfunction

    task automatic check_model(input string name);
        chk(name, 32'(obs()),
            32'({exp_we, exp_ack, exp_val, exp_rdy, exp_addr, exp_wd, exp_rd}));
    endtask

    task automatic cycle();
        @(posedge clock_50);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_model("model");
    endtask

    task automatic idle_inputs();
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vga_req   = 1'b0;
        vga_addr  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        check_model("reset_async");
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          vr;
        logic [AW-1:0] va;
        logic          e_we, e_ack, e_val, e_rdy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
    } vec_t;

    vec_t vecs [11];
    int   n_edges;

    initial begin
        vecs[0]  = '{1'b1, 10'h005, 8'h41, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 10'h005, 8'h41, 8'h00};
        vecs[2]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h010, 1'b0, 1'b1, 1'b0, 1'b1, 10'h010, 8'h41, 8'h00};
        vecs[3]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 8'h41, 8'h00};
        vecs[4]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 10'h010, 8'h41, 8'h7E};
        vecs[5]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 8'h41, 8'h7E};
        vecs[6]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h005, 1'b0, 1'b1, 1'b0, 1'b1, 10'h005, 8'h41, 8'h7E};
        vecs[7]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h010, 1'b0, 1'b1, 1'b0, 1'b1, 10'h010, 8'h41, 8'h7E};
        vecs[8]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 10'h010, 8'h41, 8'h41};
        vecs[9]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 10'h010, 8'h41, 8'h7E};
        vecs[10] = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 8'h41, 8'h7E};

        for (int i = 0; i < NRAM; i++) shadow[i] = init_val(i);
        cyc      = 0;
        idle_inputs();
        reset    = 1'b1;
        ram_load = 1'b1;
        model_reset();
        @(posedge clock_50);
        #1;
        ram_load = 1'b0;
        check_model("reset_state");
        chk("reset_ready", 32'(cpu_ready), 32'd1);
        cycle();
        reset = 1'b0;

        // single write then reads with 2-edge latency and streaming
        for (int i = 0; i < 11; i++) begin
            cpu_we    = vecs[i].we;
            cpu_addr  = vecs[i].a;
            cpu_wdata = vecs[i].d;
            vga_req   = vecs[i].vr;
            vga_addr  = vecs[i].va;
            cycle();
            chk($sformatf("vec%0d", i), 32'(obs()),
                32'({vecs[i].e_we, vecs[i].e_ack, vecs[i].e_val, vecs[i].e_rdy,
                     vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_rd}));
        end

        // full FIFO while VGA holds the port; fifth write dropped
        do_reset();
        vga_req  = 1'b1;
        vga_addr = 10'h020;
        for (int i = 0; i < 4; i++) begin
            push(AW'(10'h100 + i), DW'(8'hA0 + i));
            cycle();
        end
        chk("full_ready", 32'(cpu_ready), 32'd0);
        push(10'h1FF, 8'hEE);
        cycle();
        chk("drop_ready", 32'(cpu_ready), 32'd0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("drain%0d", i), 32'({ram_we, ram_addr, ram_wdata}),
                32'({1'b1, AW'(10'h100 + i), DW'(8'hA0 + i)}));
        end
        cycle();
        chk("drain_done_we", 32'(ram_we), 32'd0);

        // starvation: forced write on the 9th non-empty edge
        do_reset();
        vga_req  = 1'b1;
        vga_addr = 10'h030;
        push(10'h0AB, 8'h5A);
        cycle();
        cpu_we  = 1'b0;
        n_edges = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_edges++;
            if (ram_we) break;
        end
        chk("starve_edge", 32'(n_edges), 32'd9);
        chk("starve_ack", 32'(vga_ack), 32'd0);
        chk("starve_addr", 32'({ram_addr, ram_wdata}), 32'({10'h0AB, 8'h5A}));
        cycle();
        chk("starve_resume_ack", 32'(vga_ack), 32'd1);
        idle_inputs();
        cycle();

        // simultaneous push/pop at count 2
        do_reset();
        vga_req = 1'b1;
        push(10'h040, 8'h10);
        cycle();
        push(10'h041, 8'h11);
        cycle();
        vga_req = 1'b0;
        push(10'h042, 8'h12);
        cycle();
        chk("pp_pop0", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 10'h040, 8'h10}));
        chk("pp_ready", 32'(cpu_ready), 32'd1);
        cpu_we = 1'b0;
        cycle();
        chk("pp_pop1", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 10'h041, 8'h11}));
        cycle();
        chk("pp_pop2", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 10'h042, 8'h12}));
        cycle();
        chk("pp_empty", 32'(ram_we), 32'd0);

        // reset between READ grant and vga_valid
        do_reset();
        vga_req  = 1'b1;
        vga_addr = 10'h010;
        push(10'h050, 8'h77);
        cycle();
        chk("mid_ack", 32'(vga_ack), 32'd1);
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_ready", 32'(cpu_ready), 32'd1);
        chk("mid_rst_ack", 32'(vga_ack), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk($sformatf("mid_no_valid%0d", i), 32'(vga_valid), 32'd0);
        end
        reset = 1'b0;
        cycle();
        chk("mid_fifo_discard", 32'(ram_we), 32'd0);
        cycle();
        chk("mid_no_valid_late", 32'(vga_valid), 32'd0);

        // random traffic with varying VGA load
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int pct;
            pct       = ((i / 60) % 3 == 0) ? 100 : (((i / 60) % 3 == 1) ? 70 : 15);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
            vga_req   = ($urandom_range(0, 99) < pct);
            vga_addr  = AW'($urandom);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
